// File: rtl/signed_pow2_divider_pipe.sv
// Pipelined signed divide by 2^s (floor or truncate) with valid/ready backpressure on every stage.
// Define SIGNED_POW2_DIVIDER_REM_EN to add the down_r remainder output.
module signed_pow2_divider_pipe #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_a,
  input  logic [SW-1:0] up_s,
  input  logic          up_mode,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_q
`ifdef SIGNED_POW2_DIVIDER_REM_EN
  ,
  output logic [N-1:0]  down_r
`endif
);
  localparam int K = SW;

  typedef struct packed {
    logic [N-1:0]  q;
    logic [SW-1:0] s;
    logic          mode;
    logic          sticky;
`ifdef SIGNED_POW2_DIVIDER_REM_EN
    logic [N-1:0]  a;
`endif
  } stage_t;

  logic [K:0]   vld_pipe;
  logic [K:0]   vin;
  logic [K:0]   rdy;
  stage_t       src  [K+1];
  stage_t       nxt  [K];
  stage_t       pipe [K];
  logic [N-1:0] lost;
  logic         inc;
  logic [N-1:0] q_fix;
  logic [N-1:0] q_r;

  // A stage may load when it is empty or when everything downstream of it can move.
  assign vin = {vld_pipe[K-1:0], up_valid};
  for (genvar i = 0; i <= K; i++) begin : g_rdy
    assign rdy[i] = down_ready | ~(&vld_pipe[K:i]);
  end

  assign up_ready   = rdy[0];
  assign down_valid = vld_pipe[K];
  assign down_q     = q_r;

  always_comb begin
    src[0]        = '0;
    src[0].q      = up_a;
    src[0].s      = up_s;
    src[0].mode   = up_mode;
`ifdef SIGNED_POW2_DIVIDER_REM_EN
    src[0].a      = up_a;
`endif
    for (int k = 1; k <= K; k++) src[k] = pipe[k-1];
    lost = '0;
    for (int k = 0; k < K; k++) begin
      nxt[k] = src[k];
      if (src[k].s[k]) begin
        lost          = src[k].q & ((N'(1) << (1 << k)) - N'(1));
        nxt[k].q      = N'($signed(src[k].q) >>> (1 << k));
        nxt[k].sticky = src[k].sticky | (|lost);
      end
    end
  end

  // Truncation differs from floor only for negative, inexact quotients; never overflows.
  assign inc   = src[K].mode & src[K].q[N-1] & src[K].sticky;
  assign q_fix = src[K].q + {{(N-1){1'b0}}, inc};

`ifdef SIGNED_POW2_DIVIDER_REM_EN
  logic [N-1:0] r_fix;
  logic [N-1:0] r_r;
  assign r_fix  = src[K].a - (q_fix << src[K].s);
  assign down_r = r_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_r <= '0;
    else if (rdy[K]) r_r <= r_fix;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 0; k < K; k++) pipe[k] <= '0;
      q_r <= '0;
    end else begin
      for (int k = 0; k <= K; k++) if (rdy[k]) vld_pipe[k] <= vin[k];
      for (int k = 0; k < K; k++)  if (rdy[k]) pipe[k] <= nxt[k];
      if (rdy[K]) q_r <= q_fix;
    end
  end
endmodule
